// File: rtl/td4_pkg.sv
// Shared types for the TD4 sequencer: opcodes, FSM states, datapath selects
// and the decoded-instruction bundle. The HALT state exists only when
// TD4_SEQ_TRAP_EN is defined.
package td4_pkg;

  // 4-bit opcode space; 1000, 1010, 1100 and 1101 are undefined.
  typedef enum logic [3:0] {
    OpAddAIm = 4'b0000,
    OpMovAB  = 4'b0001,
    OpInA    = 4'b0010,
    OpMovAIm = 4'b0011,
    OpMovBA  = 4'b0100,
    OpAddBIm = 4'b0101,
    OpInB    = 4'b0110,
    OpMovBIm = 4'b0111,
    OpOutB   = 4'b1001,
    OpOutIm  = 4'b1011,
    OpJnc    = 4'b1110,
    OpJmp    = 4'b1111
  } opcode_e;

`ifdef TD4_SEQ_TRAP_EN
  typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StWait, StExec} state_e;
`endif

  // Datapath mux select, encoded as {sel_b, sel_a}.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef struct packed {
    logic [1:0] sel;
    logic       load_a;
    logic       load_b;
    logic       load_out;
    logic       jump;
    logic       illegal;
  } decode_t;

  // Value driven on the control outputs whenever no instruction is executing.
  localparam decode_t DecodeIdle = '{
    sel:      SEL_A,
    load_a:   1'b0,
    load_b:   1'b0,
    load_out: 1'b0,
    jump:     1'b0,
    illegal:  1'b0
  };

endpackage

// File: rtl/td4_idecode.sv
// Pure combinational TD4 instruction decoder: opcode plus carry flag to
// mux selects and load/jump/illegal indications.
module td4_idecode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       cflag,
  output decode_t    dec
);

  // Decode opcode; anything not listed is flagged illegal with the zero select.
  always_comb begin
    dec          = DecodeIdle;
    dec.sel      = SEL_ZERO;
    case (opcode)
      OpAddAIm: begin dec.sel = SEL_A;    dec.load_a   = 1'b1; end
      OpMovAB:  begin dec.sel = SEL_B;    dec.load_a   = 1'b1; end
      OpInA:    begin dec.sel = SEL_IN;   dec.load_a   = 1'b1; end
      OpMovAIm: begin dec.sel = SEL_ZERO; dec.load_a   = 1'b1; end
      OpMovBA:  begin dec.sel = SEL_A;    dec.load_b   = 1'b1; end
      OpAddBIm: begin dec.sel = SEL_B;    dec.load_b   = 1'b1; end
      OpInB:    begin dec.sel = SEL_IN;   dec.load_b   = 1'b1; end
      OpMovBIm: begin dec.sel = SEL_ZERO; dec.load_b   = 1'b1; end
      OpOutB:   begin dec.sel = SEL_B;    dec.load_out = 1'b1; end
      OpOutIm:  begin dec.sel = SEL_ZERO; dec.load_out = 1'b1; end
      OpJnc:    begin dec.sel = SEL_ZERO; dec.jump     = ~cflag; end
      OpJmp:    begin dec.sel = SEL_ZERO; dec.jump     = 1'b1; end
      default:  begin dec.sel = SEL_ZERO; dec.illegal  = 1'b1; end
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control unit: program counter, instruction register and carry flag,
// running a FETCH/WAIT/EXEC loop against instruction memory over req/ack.
// Define TD4_SEQ_TRAP_EN to make illegal opcodes halt the sequencer.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_en,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [DATA_W+3:0]   imem_data,
  input  logic                alu_carry,
  output logic                sel_a,
  output logic                sel_b,
  output logic                load_a,
  output logic                load_b,
  output logic                load_out,
  output logic                jump,
  output logic [DATA_W-1:0]   imm,
  output logic [ADDR_W-1:0]   pc,
  output logic                cflag,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W+3:0]   ir_q, ir_d;
  logic                cflag_q, cflag_d;
  decode_t             dec, dec_out;

  td4_idecode u_idecode (
    .opcode (ir_q[DATA_W+3:DATA_W]),
    .cflag  (cflag_q),
    .dec    (dec)
  );

  // State, program counter, instruction register and carry flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cflag_q <= cflag_d;
    end
  end

  // Next-state logic; decoder outputs reach the datapath only during EXEC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cflag_d  = cflag_q;
    imem_req = 1'b0;
    dec_out  = DecodeIdle;
    case (state_q)
      StFetch: begin
        if (step_en) state_d = StWait;
      end
      StWait: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        dec_out = dec;
        cflag_d = alu_carry;
        pc_d    = dec.jump ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        state_d = StFetch;
`ifdef TD4_SEQ_TRAP_EN
        // Trap: keep the faulting address visible and stop fetching.
        if (dec.illegal) begin
          pc_d    = pc_q;
          state_d = StHalt;
        end
`endif
      end
`ifdef TD4_SEQ_TRAP_EN
      StHalt: begin
        state_d = StHalt;
      end
`endif
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign sel_a     = dec_out.sel[0];
  assign sel_b     = dec_out.sel[1];
  assign load_a    = dec_out.load_a;
  assign load_b    = dec_out.load_b;
  assign load_out  = dec_out.load_out;
  assign jump      = dec_out.jump;
  assign illegal   = dec_out.illegal;
  assign imm       = ir_q[DATA_W-1:0];
  assign pc        = pc_q;
  assign cflag     = cflag_q;

endmodule
